// File: rtl/store_write_buffer_if.sv
// Store issue / bus write handshake bundle for store_write_buffer.
// master drives requests and bus_ack; slave is the buffer itself.
interface store_write_buffer_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic        exc_ades;
  logic [31:0] exc_addr;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic        buf_empty;

  modport master (
    output in_valid, in_op, in_addr, in_data, bus_ack,
    input  in_ready, exc_ades, exc_addr, bus_req,
    input  bus_addr, bus_wdata, bus_be, buf_empty
  );

  modport slave (
    input  in_valid, in_op, in_addr, in_data, bus_ack,
    output in_ready, exc_ades, exc_addr, bus_req,
    output bus_addr, bus_wdata, bus_be, buf_empty
  );
endinterface

// File: rtl/store_write_buffer.sv
// Store narrowing, AdES detection and write FIFO toward the data bus.
// Optional STORE_RANGE_CHECK_EN also rejects stores outside DM/TC windows.
module store_write_buffer #(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input logic             clk,
  input logic             reset,
  store_write_buffer_if.slave sb
);

  localparam logic [PTR_W:0] CNT_MAX = (PTR_W+1)'(DEPTH);

  logic [29:0]      addr_q  [DEPTH];
  logic [31:0]      wdata_q [DEPTH];
  logic [3:0]       be_q    [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             exc_ades_q;
  logic [31:0]      exc_addr_q;

  logic        is_sb, is_sh, is_sw;
  logic        mis, illegal;
  logic        take, reject, push, pop;
  logic        empty;
  logic [31:0] enc_wdata;
  logic [3:0]  enc_be;

  assign is_sb = (sb.in_op == 2'b01);
  assign is_sh = (sb.in_op == 2'b10);
  assign is_sw = (sb.in_op == 2'b11);

  always_comb begin
    mis       = 1'b0;
    enc_wdata = '0;
    enc_be    = '0;
    unique case (1'b1)
      is_sb: begin
        enc_wdata = {4{sb.in_data[7:0]}};
        enc_be    = 4'b0001 << sb.in_addr[1:0];
      end
      is_sh: begin
        mis       = sb.in_addr[0];
        enc_wdata = {2{sb.in_data[15:0]}};
        enc_be    = sb.in_addr[1] ? 4'b1100 : 4'b0011;
      end
      is_sw: begin
        mis       = |sb.in_addr[1:0];
        enc_wdata = sb.in_data;
        enc_be    = 4'b1111;
      end
      default: ;
    endcase
  end

`ifdef STORE_RANGE_CHECK_EN
  logic in_dm, in_tc;
  assign in_dm = (sb.in_addr <= 32'h0000_2FFF);
  // Timer/counter blocks only decode full words.
  assign in_tc =
    ((sb.in_addr >= 32'h0000_7F00) && (sb.in_addr <= 32'h0000_7F0B)) ||
    ((sb.in_addr >= 32'h0000_7F10) && (sb.in_addr <= 32'h0000_7F1B));
  assign illegal = !(in_dm || (is_sw && in_tc));
`else
  assign illegal = 1'b0;
`endif

  assign empty  = (count_q == '0);
  assign take   = sb.in_valid && sb.in_ready && (sb.in_op != 2'b00);
  assign reject = take && (mis || illegal);
  assign push   = take && !reject;
  assign pop    = sb.bus_ack && !empty;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      exc_ades_q <= 1'b0;
      exc_addr_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      exc_ades_q <= reject;
      if (reject) exc_addr_q <= sb.in_addr;
    end
  end

  // Payload needs no reset: every bus output is masked while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q]  <= sb.in_addr[31:2];
      wdata_q[wr_ptr_q] <= enc_wdata;
      be_q[wr_ptr_q]    <= enc_be;
    end
  end

  assign sb.in_ready  = (count_q < CNT_MAX);
  assign sb.buf_empty = empty;
  assign sb.exc_ades  = exc_ades_q;
  assign sb.exc_addr  = exc_addr_q;
  assign sb.bus_req   = !empty;
  assign sb.bus_addr  = empty ? '0 : {addr_q[rd_ptr_q], 2'b00};
  assign sb.bus_wdata = empty ? '0 : wdata_q[rd_ptr_q];
  assign sb.bus_be    = empty ? '0 : be_q[rd_ptr_q];

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed bench for store_write_buffer: encode table plus
// full/stream/reset sequences.
module tb_store_write_buffer;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  store_write_buffer_if bif ();

  store_write_buffer #(.DEPTH(2), .PTR_W(1)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic        exc;
    logic        req;
    logic [31:0] baddr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] d);
    bif.in_valid = v;
    bif.in_op    = op;
    bif.in_addr  = a;
    bif.in_data  = d;
  endtask

  initial begin
    logic [31:0] last_exc;
    vec_t v;
    checks   = 0;
    errors   = 0;
    last_exc = '0;
    reset    = 1'b0;
    drive(1'b0, 2'b00, '0, '0);
    bif.bus_ack = 1'b0;

    vq.push_back('{2'b01, 32'h13, 32'h1234_56AB, 1'b0, 1'b1,
                   32'h10, 32'hABAB_ABAB, 4'b1000});
    vq.push_back('{2'b01, 32'h0, 32'h0000_00CD, 1'b0, 1'b1,
                   32'h0, 32'hCDCD_CDCD, 4'b0001});
    vq.push_back('{2'b01, 32'h21, 32'h0000_00FF, 1'b0, 1'b1,
                   32'h20, 32'hFFFF_FFFF, 4'b0010});
    vq.push_back('{2'b01, 32'h2, 32'h5555_5577, 1'b0, 1'b1,
                   32'h0, 32'h7777_7777, 4'b0100});
    vq.push_back('{2'b10, 32'h6, 32'hDEAD_BEEF, 1'b0, 1'b1,
                   32'h4, 32'hBEEF_BEEF, 4'b1100});
    vq.push_back('{2'b10, 32'h8, 32'hCAFE_1234, 1'b0, 1'b1,
                   32'h8, 32'h1234_1234, 4'b0011});
    vq.push_back('{2'b10, 32'h5, 32'h1111_2222, 1'b1, 1'b0,
                   32'h0, 32'h0, 4'b0000});
    vq.push_back('{2'b11, 32'h100, 32'h89AB_CDEF, 1'b0, 1'b1,
                   32'h100, 32'h89AB_CDEF, 4'b1111});
    vq.push_back('{2'b11, 32'h102, 32'h0, 1'b1, 1'b0,
                   32'h0, 32'h0, 4'b0000});
    vq.push_back('{2'b11, 32'h7, 32'h0, 1'b1, 1'b0,
                   32'h0, 32'h0, 4'b0000});
    vq.push_back('{2'b00, 32'h40, 32'hFFFF_FFFF, 1'b0, 1'b0,
                   32'h0, 32'h0, 4'b0000});
`ifdef STORE_RANGE_CHECK_EN
    vq.push_back('{2'b11, 32'h3000, 32'h0101_0101, 1'b1, 1'b0,
                   32'h0, 32'h0, 4'b0000});
    vq.push_back('{2'b11, 32'h7F04, 32'h0202_0202, 1'b0, 1'b1,
                   32'h7F04, 32'h0202_0202, 4'b1111});
    vq.push_back('{2'b01, 32'h7F10, 32'h0000_0033, 1'b1, 1'b0,
                   32'h0, 32'h0, 4'b0000});
`else
    vq.push_back('{2'b11, 32'h3000, 32'h0101_0101, 1'b0, 1'b1,
                   32'h3000, 32'h0101_0101, 4'b1111});
    vq.push_back('{2'b01, 32'h7F10, 32'h0000_0033, 1'b0, 1'b1,
                   32'h7F10, 32'h3333_3333, 4'b0001});
`endif

    // Reset state
    #12;
    chk("rst_in_ready", 32'(bif.in_ready), 32'd1);
    chk("rst_empty", 32'(bif.buf_empty), 32'd1);
    chk("rst_req", 32'(bif.bus_req), 32'd0);
    chk("rst_be", 32'(bif.bus_be), 32'd0);
    chk("rst_addr", bif.bus_addr, 32'd0);
    chk("rst_wdata", bif.bus_wdata, 32'd0);
    chk("rst_exc", 32'(bif.exc_ades), 32'd0);
    chk("rst_exc_addr", bif.exc_addr, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step();

    // Encoding / alignment table
    foreach (vq[i]) begin
      v = vq[i];
      drive(1'b1, v.op, v.addr, v.data);
      bif.bus_ack = 1'b0;
      step();
      drive(1'b0, 2'b00, '0, '0);
      chk($sformatf("v%0d_exc", i), 32'(bif.exc_ades), 32'(v.exc));
      if (v.exc) last_exc = v.addr;
      chk($sformatf("v%0d_exc_addr", i), bif.exc_addr, last_exc);
      chk($sformatf("v%0d_req", i), 32'(bif.bus_req), 32'(v.req));
      if (v.req) begin
        chk($sformatf("v%0d_baddr", i), bif.bus_addr, v.baddr);
        chk($sformatf("v%0d_wdata", i), bif.bus_wdata, v.wdata);
        chk($sformatf("v%0d_be", i), 32'(bif.bus_be), 32'(v.be));
      end else begin
        chk($sformatf("v%0d_be0", i), 32'(bif.bus_be), 32'd0);
        chk($sformatf("v%0d_empty", i), 32'(bif.buf_empty), 32'd1);
      end
      bif.bus_ack = v.req;
      step();
      bif.bus_ack = 1'b0;
      chk($sformatf("v%0d_exc_pulse", i), 32'(bif.exc_ades), 32'd0);
      chk($sformatf("v%0d_drained", i), 32'(bif.buf_empty), 32'd1);
    end

    // Full buffer, third store refused, FIFO order
    drive(1'b1, 2'b11, 32'h0, 32'h1111_1111);
    step();
    drive(1'b1, 2'b11, 32'h4, 32'h2222_2222);
    step();
    chk("full_ready", 32'(bif.in_ready), 32'd0);
    chk("full_head", bif.bus_addr, 32'h0);
    chk("full_wdata", bif.bus_wdata, 32'h1111_1111);
    drive(1'b1, 2'b11, 32'h8, 32'h3333_3333);
    step();
    chk("full_hold_ready", 32'(bif.in_ready), 32'd0);
    chk("full_hold_head", bif.bus_addr, 32'h0);
    drive(1'b0, 2'b00, '0, '0);
    bif.bus_ack = 1'b1;
    step();
    chk("pop1_head", bif.bus_addr, 32'h4);
    chk("pop1_wdata", bif.bus_wdata, 32'h2222_2222);
    chk("pop1_ready", 32'(bif.in_ready), 32'd1);
    step();
    bif.bus_ack = 1'b0;
    chk("pop2_empty", 32'(bif.buf_empty), 32'd1);
    chk("pop2_req", 32'(bif.bus_req), 32'd0);

    // Streaming with ack held high
    bif.bus_ack = 1'b1;
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 2'b11, 32'h40 + 32'(4 * k), 32'(k + 100));
      step();
      chk($sformatf("st%0d_req", k), 32'(bif.bus_req), 32'd1);
      chk($sformatf("st%0d_addr", k), bif.bus_addr, 32'h40 + 32'(4 * k));
      chk($sformatf("st%0d_wdata", k), bif.bus_wdata, 32'(k + 100));
      chk($sformatf("st%0d_ready", k), 32'(bif.in_ready), 32'd1);
    end
    drive(1'b0, 2'b00, '0, '0);
    step();
    bif.bus_ack = 1'b0;
    chk("st_drain", 32'(bif.buf_empty), 32'd1);

    // Asynchronous reset with two entries queued
    drive(1'b1, 2'b11, 32'h80, 32'hAAAA_AAAA);
    step();
    drive(1'b1, 2'b01, 32'h85, 32'h0000_00BB);
    step();
    drive(1'b0, 2'b00, '0, '0);
    chk("pre_rst_req", 32'(bif.bus_req), 32'd1);
    chk("pre_rst_ready", 32'(bif.in_ready), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_req", 32'(bif.bus_req), 32'd0);
    chk("arst_be", 32'(bif.bus_be), 32'd0);
    chk("arst_empty", 32'(bif.buf_empty), 32'd1);
    chk("arst_ready", 32'(bif.in_ready), 32'd1);
    chk("arst_exc_addr", bif.exc_addr, 32'd0);
    #3;
    reset = 1'b1;
    step();
    chk("post_rst_empty", 32'(bif.buf_empty), 32'd1);
    chk("post_rst_req", 32'(bif.bus_req), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
